// File: rtl/app_arb_pkg.sv
// Shared types and widths for the app_data buffer arbiter and its helpers.
package app_arb_pkg;

  // Arbiter control states; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANTED = 2'b01,
    ST_GAP     = 2'b10
  } arb_state_e;

  localparam int OWNER_W   = 3;
  localparam int TMO_CNT_W = 16;

  // Saturating increment for the revocation counter.
  function automatic logic [TMO_CNT_W-1:0] sat_inc(input logic [TMO_CNT_W-1:0] v);
    logic [TMO_CNT_W-1:0] r;
    if (v == {TMO_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + TMO_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/app_data_arbiter_if.sv
// Request/grant bundle between the app_data requesters and the arbiter.
interface app_data_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import app_arb_pkg::*;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   rel;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic [OWNER_W-1:0]   owner;
  logic                 timeout_evt;
  logic [TMO_CNT_W-1:0] timeout_cnt;

  // Requester side: drives pulses, observes ownership.
  modport master (
    output req, rel,
    input  grant, busy, owner, timeout_evt, timeout_cnt
  );

  // Arbiter side.
  modport slave (
    input  req, rel,
    output grant, busy, owner, timeout_evt, timeout_cnt
  );

endinterface

// File: rtl/app_data_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set candidate after
// index 'last', wrapping modulo N. 'last' itself has the lowest priority.
module rr_pick import app_arb_pkg::*; #(
  parameter int N = 2
) (
  input  logic [N-1:0]       cand,
  input  logic [OWNER_W-1:0] last,
  output logic               valid,
  output logic [OWNER_W-1:0] pick
);

  // Nearest set candidate by wrapped distance from last+1.
  always_comb begin
    int dist_s;
    int best_s;
    valid  = 1'b0;
    pick   = {OWNER_W{1'b0}};
    best_s = N;
    dist_s = 0;
    for (int i = 0; i < N; i++) begin
      dist_s = (((i - int'(last) - 1) % N) + N) % N;
      if (cand[i] && (dist_s < best_s)) begin
        valid  = 1'b1;
        pick   = OWNER_W'(i);
        best_s = dist_s;
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/app_data_arbiter.sv
// Arbiter for the shared ROS2 app_data buffer: round-robin grant among
// NUM_REQ requesters, one idle cycle between owners, and a watchdog that
// revokes a grant held for TIMEOUT_CYCLES cycles (0 disables it).
module app_data_arbiter import app_arb_pkg::*; #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int TMO_WIDTH      = 32
) (
  input logic               clk_int,
  input logic               rst_int,
  app_data_arbiter_if.slave bus
);

  localparam bit                   TMO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST    = TMO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0]   ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [OWNER_W-1:0]   OWNER_RST   = OWNER_W'(NUM_REQ - 1);

  arb_state_e           state_r;
  arb_state_e           state_nxt_s;
  logic [NUM_REQ-1:0]   grant_r;
  logic [NUM_REQ-1:0]   grant_nxt_s;
  logic [NUM_REQ-1:0]   grant_set_s;
  logic [NUM_REQ-1:0]   pending_r;
  logic [NUM_REQ-1:0]   pending_nxt_s;
  logic [NUM_REQ-1:0]   cand_s;
  logic [OWNER_W-1:0]   owner_r;
  logic [OWNER_W-1:0]   owner_nxt_s;
  logic [OWNER_W-1:0]   pick_s;
  logic                 pick_valid_s;
  logic [TMO_WIDTH-1:0] hold_r;
  logic [TMO_WIDTH-1:0] hold_nxt_s;
  logic                 busy_r;
  logic                 evt_r;
  logic                 evt_nxt_s;
  logic [TMO_CNT_W-1:0] tmo_cnt_r;
  logic [TMO_CNT_W-1:0] tmo_cnt_nxt_s;
  logic                 rel_own_s;
  logic                 tmo_hit_s;

  // The owner's own request while it holds the grant is dropped, so only
  // non-granted requesters feed the candidate set.
  assign cand_s    = pending_r | (bus.req & ~grant_r);
  assign rel_own_s = |(bus.rel & grant_r);
  assign tmo_hit_s = TMO_EN && (hold_r == TMO_LAST);

  rr_pick #(.N(NUM_REQ)) u_pick (
    .cand  (cand_s),
    .last  (owner_r),
    .valid (pick_valid_s),
    .pick  (pick_s)
  );

  // State register.
  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state. GAP may hand straight to the next owner, which keeps the
  // zero-grant window between owners at exactly one cycle.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = ST_GRANTED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        if (rel_own_s || tmo_hit_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_GRANTED;
        end
      end
      ST_GAP: begin
        if (pick_valid_s) begin
          state_nxt_s = ST_GRANTED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next values of grant, owner, hold counter and watchdog outputs.
  always_comb begin
    grant_nxt_s   = {NUM_REQ{1'b0}};
    grant_set_s   = {NUM_REQ{1'b0}};
    owner_nxt_s   = owner_r;
    hold_nxt_s    = hold_r;
    evt_nxt_s     = 1'b0;
    tmo_cnt_nxt_s = tmo_cnt_r;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (pick_valid_s) begin
          grant_set_s = ONE_HOT_LSB << pick_s;
          grant_nxt_s = grant_set_s;
          owner_nxt_s = pick_s;
          hold_nxt_s  = {TMO_WIDTH{1'b0}};
        end else begin
          grant_nxt_s = {NUM_REQ{1'b0}};
        end
      end
      ST_GRANTED: begin
        hold_nxt_s = hold_r + TMO_WIDTH'(1);
        if (rel_own_s) begin
          grant_nxt_s = {NUM_REQ{1'b0}};
        end else if (tmo_hit_s) begin
          grant_nxt_s   = {NUM_REQ{1'b0}};
          evt_nxt_s     = 1'b1;
          tmo_cnt_nxt_s = sat_inc(tmo_cnt_r);
        end else begin
          grant_nxt_s = grant_r;
        end
      end
      default: begin
        grant_nxt_s = {NUM_REQ{1'b0}};
      end
    endcase
    pending_nxt_s = cand_s & ~grant_set_s;
  end

  // Registered outputs and bookkeeping.
  always_ff @(posedge clk_int) begin
    if (rst_int) begin
      grant_r   <= {NUM_REQ{1'b0}};
      busy_r    <= 1'b0;
      owner_r   <= OWNER_RST;
      evt_r     <= 1'b0;
      tmo_cnt_r <= {TMO_CNT_W{1'b0}};
      pending_r <= {NUM_REQ{1'b0}};
      hold_r    <= {TMO_WIDTH{1'b0}};
    end else begin
      grant_r   <= grant_nxt_s;
      busy_r    <= |grant_nxt_s;
      owner_r   <= owner_nxt_s;
      evt_r     <= evt_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
      pending_r <= pending_nxt_s;
      hold_r    <= hold_nxt_s;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.busy        = busy_r;
  assign bus.owner       = owner_r;
  assign bus.timeout_evt = evt_r;
  assign bus.timeout_cnt = tmo_cnt_r;

endmodule

// File: tb/tb_app_data_arbiter.sv
// Directed bench for app_data_arbiter: a 4-requester instance with a
// 10-cycle watchdog and a 2-requester instance with the watchdog disabled.
module tb_app_data_arbiter;

  typedef struct {
    string       tag;
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic        evt;
    logic [15:0] cnt;
  } exp_t;

  logic clk_int = 1'b0;
  logic rst_int = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [3:0] prev_grant = 4'b0000;

  app_data_arbiter_if #(.NUM_REQ(4)) bus_a ();
  app_data_arbiter_if #(.NUM_REQ(2)) bus_b ();

  app_data_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(10), .TMO_WIDTH(8)) dut_a (
    .clk_int (clk_int),
    .rst_int (rst_int),
    .bus     (bus_a)
  );

  app_data_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(0), .TMO_WIDTH(32)) dut_b (
    .clk_int (clk_int),
    .rst_int (rst_int),
    .bus     (bus_b)
  );

  always #5 clk_int = ~clk_int;

  task automatic check(input exp_t x, input logic [3:0] g, input logic [2:0] o,
                       input logic e, input logic [15:0] c, input logic b);
    tests++;
    assert (g === x.grant) else begin
      fails++; $error("FAIL %s grant got %b exp %b", x.tag, g, x.grant);
    end
    tests++;
    assert (o === x.owner) else begin
      fails++; $error("FAIL %s owner got %0d exp %0d", x.tag, o, x.owner);
    end
    tests++;
    assert (e === x.evt) else begin
      fails++; $error("FAIL %s timeout_evt got %b exp %b", x.tag, e, x.evt);
    end
    tests++;
    assert (c === x.cnt) else begin
      fails++; $error("FAIL %s timeout_cnt got %0d exp %0d", x.tag, c, x.cnt);
    end
    tests++;
    assert (b === (|x.grant)) else begin
      fails++; $error("FAIL %s busy got %b exp %b", x.tag, b, |x.grant);
    end
  endtask

  // Drive one cycle of pulses on A, queue the expected post-edge outputs.
  task automatic tick_a(input logic [3:0] r, input logic [3:0] l, input logic [3:0] g,
                        input logic [2:0] o, input logic e, input logic [15:0] c,
                        input string tag);
    exp_t x;
    bus_a.req = r;
    bus_a.rel = l;
    x.tag = tag; x.grant = g; x.owner = o; x.evt = e; x.cnt = c;
    q_a.push_back(x);
    @(posedge clk_int);
    #1;
    bus_a.req = 4'b0000;
    bus_a.rel = 4'b0000;
    x = q_a.pop_front();
    check(x, bus_a.grant, bus_a.owner, bus_a.timeout_evt, bus_a.timeout_cnt, bus_a.busy);
  endtask

  task automatic tick_b(input logic [1:0] r, input logic [1:0] l, input logic [1:0] g,
                        input logic [2:0] o, input logic e, input logic [15:0] c,
                        input string tag);
    exp_t x;
    bus_b.req = r;
    bus_b.rel = l;
    x.tag = tag; x.grant = {2'b00, g}; x.owner = o; x.evt = e; x.cnt = c;
    q_b.push_back(x);
    @(posedge clk_int);
    #1;
    bus_b.req = 2'b00;
    bus_b.rel = 2'b00;
    x = q_b.pop_front();
    check(x, {2'b00, bus_b.grant}, bus_b.owner, bus_b.timeout_evt, bus_b.timeout_cnt,
          bus_b.busy);
  endtask

  // Grant on A is never multi-hot and never hands directly between owners.
  always @(negedge clk_int) begin
    if (!rst_int) begin
      tests++;
      assert ($onehot0(bus_a.grant) === 1'b1) else begin
        fails++; $error("FAIL onehot grant got %b exp at most one bit", bus_a.grant);
      end
      if ((prev_grant != 4'b0000) && (bus_a.grant != 4'b0000)) begin
        tests++;
        assert (bus_a.grant === prev_grant) else begin
          fails++; $error("FAIL handoff_gap grant got %b exp %b or 0000", bus_a.grant, prev_grant);
        end
      end
    end
    prev_grant = bus_a.grant;
  end

  initial begin
    logic [3:0] m;
    logic [3:0] nm;
    bus_a.req = 4'b0000; bus_a.rel = 4'b0000;
    bus_b.req = 2'b00;   bus_b.rel = 2'b00;

    rst_int = 1'b1;
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd3, 1'b0, 16'd0, "reset_a");
    tick_b(2'b00, 2'b00, 2'b00, 3'd1, 1'b0, 16'd0, "reset_b");
    rst_int = 1'b0;

    // Simultaneous first requests: index 0 first, then 1, then pending 0.
    tick_a(4'b0011, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "simul_first");
    tick_a(4'b0000, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "simul_hold");
    tick_a(4'b0000, 4'b0001, 4'b0000, 3'd0, 1'b0, 16'd0, "simul_rel0_gap");
    tick_a(4'b0000, 4'b0000, 4'b0010, 3'd1, 1'b0, 16'd0, "simul_grant1");
    tick_a(4'b0001, 4'b0000, 4'b0010, 3'd1, 1'b0, 16'd0, "simul_req0_pend");
    tick_a(4'b0000, 4'b0010, 4'b0000, 3'd1, 1'b0, 16'd0, "simul_rel1_gap");
    tick_a(4'b0000, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "simul_regrant0");

    // Ignored events.
    tick_a(4'b0000, 4'b0010, 4'b0001, 3'd0, 1'b0, 16'd0, "ign_rel_nonowner");
    tick_a(4'b0001, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "ign_req_owner");
    tick_a(4'b0000, 4'b0001, 4'b0000, 3'd0, 1'b0, 16'd0, "ign_rel0_gap");
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0, 16'd0, "ign_idle");
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0, 16'd0, "ign_still_idle");

    // Single request latency and release.
    tick_a(4'b0001, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "single_grant");
    tick_a(4'b0000, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "single_hold");
    tick_a(4'b0000, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "single_hold");
    tick_a(4'b0000, 4'b0001, 4'b0000, 3'd0, 1'b0, 16'd0, "single_rel_gap");
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0, 16'd0, "single_idle");

    // Watchdog: grant held exactly 10 cycles, then revoked.
    tick_a(4'b0010, 4'b0000, 4'b0010, 3'd1, 1'b0, 16'd0, "wd_grant");
    for (int i = 0; i < 9; i++) begin
      tick_a(4'b0000, 4'b0000, 4'b0010, 3'd1, 1'b0, 16'd0, "wd_hold");
    end
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b1, 16'd1, "wd_revoke");
    tick_a(4'b0000, 4'b0010, 4'b0000, 3'd1, 1'b0, 16'd1, "wd_late_rel");
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0, 16'd1, "wd_idle");

    // Reset mid-grant with a pending request.
    tick_a(4'b0010, 4'b0000, 4'b0010, 3'd1, 1'b0, 16'd1, "rst_grant1");
    tick_a(4'b0001, 4'b0000, 4'b0010, 3'd1, 1'b0, 16'd1, "rst_req0_pend");
    rst_int = 1'b1;
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd3, 1'b0, 16'd0, "rst_mid");
    rst_int = 1'b0;
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd3, 1'b0, 16'd0, "rst_no_grant");
    tick_a(4'b0000, 4'b0000, 4'b0000, 3'd3, 1'b0, 16'd0, "rst_no_grant");

    // Round-robin: everyone re-requests, each holds 3 cycles.
    tick_a(4'b1111, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "rr_first");
    for (int k = 0; k < 4; k++) begin
      m  = 4'b0001 << k;
      nm = 4'b0001 << ((k + 1) % 4);
      tick_a(4'b0000, 4'b0000, m, 3'(k), 1'b0, 16'd0, "rr_hold");
      tick_a(4'b0000, 4'b0000, m, 3'(k), 1'b0, 16'd0, "rr_hold");
      tick_a(4'b0000, m, 4'b0000, 3'(k), 1'b0, 16'd0, "rr_gap");
      tick_a(m, 4'b0000, nm, 3'((k + 1) % 4), 1'b0, 16'd0, "rr_next");
    end
    tick_a(4'b0000, 4'b0000, 4'b0001, 3'd0, 1'b0, 16'd0, "rr_hold_last");

    // Watchdog disabled: long hold never revoked.
    tick_b(2'b01, 2'b00, 2'b01, 3'd0, 1'b0, 16'd0, "b_grant");
    for (int i = 0; i < 25; i++) begin
      tick_b(2'b00, 2'b00, 2'b01, 3'd0, 1'b0, 16'd0, "b_hold_no_tmo");
    end
    tick_b(2'b00, 2'b01, 2'b00, 3'd0, 1'b0, 16'd0, "b_rel");
    tick_b(2'b00, 2'b00, 2'b00, 3'd0, 1'b0, 16'd0, "b_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
